cpu_trace_capture: RTL and testbench
====================================

CPU_TRACE_CAPTURE -- requirements
Module: cpu_trace_capture

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: char  input  8  ASCII trace character; the same stream fed to cpu_checker, one char per clk.
REQ-004 SHALL have port: format_type  input  2  cpu_checker verdict: 0 none/invalid, 1 register write, 2 memory write; nonzero only in the cycle after the terminating '#' is registered.
REQ-005 SHALL have port: rec_ready  input  1  downstream accepts the record.
REQ-006 SHALL have port: rec_valid  output  1  record held.
REQ-007 SHALL have port: rec_type  output  2  copy of format_type at capture.
REQ-008 SHALL have port: rec_time  output  16  decimal time field, binary.
REQ-009 SHALL have port: rec_pc  output  32  hex PC field.
REQ-010 SHALL have port: rec_dst  output  32  register number (type 1) or memory address (type 2).
REQ-011 SHALL have port: rec_data  output  32  hex data field.
REQ-012 SHALL have port: overflow  output  1  sticky; a valid record was dropped.

Function
REQ-013 SHALL run a field FSM with states IDLE, TIME, PC, SEP, GRF, ADDR, PREDATA, DATA, DONE.
REQ-014 SHALL, on '^' from any state, enter TIME and clear all four accumulators.
REQ-015 SHALL make these transitions: TIME+'@' -> PC; PC+':' -> SEP; SEP+'$' -> GRF; SEP+'*' -> ADDR; GRF/ADDR+'<' -> PREDATA; PREDATA+'=' -> DATA; DATA+'#' -> DONE; DONE+non-'^' -> IDLE.
REQ-016 SHALL ignore chars other than the state's digits and delimiters, with no state change; space, '<' and '=' are never accumulated.
REQ-017 SHALL accumulate decimal digits '0'-'9' as acc*10+d in TIME and GRF.
REQ-018 SHALL accumulate hex digits 0-9 and a-f as (acc<<4)|h in PC, ADDR and DATA; uppercase is ignored.
REQ-019 SHALL keep only the low 16 (time) or 32 (others) bits of an accumulator, wrapping silently.
REQ-020 SHALL, when format_type!=0 and the FSM is in DONE, load the output registers on that edge; rec_valid=1 from the next cycle.
REQ-021 SHALL NOT change outputs when format_type=0 while in DONE.
REQ-022 SHALL clear rec_valid on the edge where rec_valid&&rec_ready.
REQ-023 SHALL, when a load and an accept occur on the same edge, load the new record and keep rec_valid=1.
REQ-024 SHALL, on a load while rec_valid=1 and rec_ready=0, drop the new record, keep the old one and set overflow.
REQ-025 SHALL keep rec_* stable while rec_valid=1.

Reset
REQ-026 SHALL, while reset is high, force FSM=IDLE, accumulators=0, rec_valid=0, rec_type=0, rec_time=0, rec_pc=0, rec_dst=0, rec_data=0 and overflow=0.
REQ-027 SHALL discard a line in progress when reset is asserted mid-line; capture resumes at the next '^' after release.

Structure
REQ-028 SHALL place FSM state encoding, FORMAT_NONE/REG/MEM constants and delimiter char constants in package cpu_trace_pkg.
REQ-029 SHALL use one combinational sub-module, trace_char_class, that outputs is_dec, is_hex and the 4-bit nibble value for char.

Verification
REQ-030 SHALL cover: "^242@000030f4: $31 <= 12345678#", format_type=1, rec_ready=1 -> one-cycle rec_valid, time=242, pc=0x000030F4, dst=31, data=0x12345678.
REQ-031 SHALL cover: "^338@00003130: *00000088 <= ffffb528#", format_type=2 -> type=2, time=338, pc=0x00003130, dst=0x88, data=0xFFFFB528.
REQ-032 SHALL cover: "...<= 1232158998#" with format_type=0 -> rec_valid stays 0 and outputs are unchanged.
REQ-033 SHALL cover: rec_ready=0 with two valid lines back-to-back -> first record held and overflow=1; then rec_ready=1 -> rec_valid clears the next edge and overflow stays 1.
REQ-034 SHALL cover: reset pulsed after "^242@0000" and then the REQ-030 line -> outputs 0 during reset, then the REQ-030 values.
REQ-035 SHALL cover: rec_ready tied 1 with a load on the accept edge -> rec_valid stays high and the second record's fields appear.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace line capture block.
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TIME,
    S_PC,
    S_SEP,
    S_GRF,
    S_ADDR,
    S_PREDATA,
    S_DATA,
    S_DONE
  } state_e;

  localparam logic [1:0] FORMAT_NONE = 2'd0;
  localparam logic [1:0] FORMAT_REG  = 2'd1;
  localparam logic [1:0] FORMAT_MEM  = 2'd2;

  localparam logic [7:0] CH_START  = 8'h5E; // '^'
  localparam logic [7:0] CH_AT     = 8'h40; // '@'
  localparam logic [7:0] CH_COLON  = 8'h3A; // ':'
  localparam logic [7:0] CH_DOLLAR = 8'h24; // '$'
  localparam logic [7:0] CH_STAR   = 8'h2A; // '*'
  localparam logic [7:0] CH_LT     = 8'h3C; // '<'
  localparam logic [7:0] CH_EQ     = 8'h3D; // '='
  localparam logic [7:0] CH_HASH   = 8'h23; // '#'

endpackage

// File: rtl/cpu_trace_capture_if.sv
// Trace character stream in, captured record handshake out.
interface cpu_trace_capture_if;
  logic [7:0]  char;
  logic [1:0]  format_type;
  logic        rec_ready;
  logic        rec_valid;
  logic [1:0]  rec_type;
  logic [15:0] rec_time;
  logic [31:0] rec_pc;
  logic [31:0] rec_dst;
  logic [31:0] rec_data;
  logic        overflow;

  modport master (
    output char, format_type, rec_ready,
    input  rec_valid, rec_type, rec_time, rec_pc, rec_dst, rec_data, overflow
  );

  modport slave (
    input  char, format_type, rec_ready,
    output rec_valid, rec_type, rec_time, rec_pc, rec_dst, rec_data, overflow
  );
endinterface

// File: rtl/trace_char_class.sv
// Classifies one ASCII char as decimal / lowercase-hex digit and yields its nibble.
module trace_char_class (
  input  logic [7:0] i_char,
  output logic       o_is_dec,
  output logic       o_is_hex,
  output logic [3:0] o_nibble
);
  always_comb begin
    o_is_dec = 1'b0;
    o_is_hex = 1'b0;
    o_nibble = 4'd0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      o_is_dec = 1'b1;
      o_is_hex = 1'b1;
      o_nibble = i_char[3:0];
    end else if (i_char >= 8'h61 && i_char <= 8'h66) begin
      // 'a'..'f' have low nibble 1..6
      o_is_hex = 1'b1;
      o_nibble = i_char[3:0] + 4'd9;
    end
  end
endmodule

// File: rtl/cpu_trace_capture.sv
// Parses "^time@pc: $reg <= data#" / "*addr" trace lines and holds one record for downstream.
module cpu_trace_capture
  import cpu_trace_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  cpu_trace_capture_if.slave         bus
);

  state_e      r_state, w_next;
  logic [15:0] r_time;
  logic [31:0] r_pc, r_dst, r_data;
  logic        w_is_dec, w_is_hex;
  logic [3:0]  w_nib;
  logic        w_start, w_load, w_accept;

  logic        r_valid, r_overflow;
  logic [1:0]  r_type;
  logic [15:0] r_rec_time;
  logic [31:0] r_rec_pc, r_rec_dst, r_rec_data;

  trace_char_class u_class (
    .i_char   (bus.char),
    .o_is_dec (w_is_dec),
    .o_is_hex (w_is_hex),
    .o_nibble (w_nib)
  );

  assign w_start  = (bus.char == CH_START);
  assign w_load   = (r_state == S_DONE) && (bus.format_type != FORMAT_NONE);
  assign w_accept = r_valid && bus.rec_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = S_TIME;
    end else begin
      case (r_state)
        S_TIME:    if (bus.char == CH_AT)     w_next = S_PC;
        S_PC:      if (bus.char == CH_COLON)  w_next = S_SEP;
        S_SEP: begin
          if (bus.char == CH_DOLLAR)    w_next = S_GRF;
          else if (bus.char == CH_STAR) w_next = S_ADDR;
        end
        S_GRF,
        S_ADDR:    if (bus.char == CH_LT)     w_next = S_PREDATA;
        S_PREDATA: if (bus.char == CH_EQ)     w_next = S_DATA;
        S_DATA:    if (bus.char == CH_HASH)   w_next = S_DONE;
        S_DONE:    w_next = S_IDLE;
        default:   w_next = r_state;
      endcase
    end
  end

  // Accumulators survive DONE so the record can be loaded in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_time <= '0;
      r_pc   <= '0;
      r_dst  <= '0;
      r_data <= '0;
    end else if (w_start) begin
      r_time <= '0;
      r_pc   <= '0;
      r_dst  <= '0;
      r_data <= '0;
    end else begin
      case (r_state)
        S_TIME: if (w_is_dec) r_time <= r_time * 16'd10 + {12'd0, w_nib};
        S_GRF:  if (w_is_dec) r_dst  <= r_dst * 32'd10 + {28'd0, w_nib};
        S_PC:   if (w_is_hex) r_pc   <= {r_pc[27:0], w_nib};
        S_ADDR: if (w_is_hex) r_dst  <= {r_dst[27:0], w_nib};
        S_DATA: if (w_is_hex) r_data <= {r_data[27:0], w_nib};
        default: ;
      endcase
    end
  end

  // A load wins over an accept; a load into a held, unaccepted record is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_type     <= '0;
      r_rec_time <= '0;
      r_rec_pc   <= '0;
      r_rec_dst  <= '0;
      r_rec_data <= '0;
    end else if (w_load && (!r_valid || bus.rec_ready)) begin
      r_valid    <= 1'b1;
      r_type     <= bus.format_type;
      r_rec_time <= r_time;
      r_rec_pc   <= r_pc;
      r_rec_dst  <= r_dst;
      r_rec_data <= r_data;
    end else if (w_load) begin
      r_overflow <= 1'b1;
    end else if (w_accept) begin
      r_valid    <= 1'b0;
    end
  end

  assign bus.rec_valid = r_valid;
  assign bus.rec_type  = r_type;
  assign bus.rec_time  = r_rec_time;
  assign bus.rec_pc    = r_rec_pc;
  assign bus.rec_dst   = r_rec_dst;
  assign bus.rec_data  = r_rec_data;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Directed bench for cpu_trace_capture: register/memory lines, backpressure, reset mid-line.
module tb_cpu_trace_capture;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  cpu_trace_capture_if bus_if ();

  cpu_trace_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus_if.char = s[i];
      tick();
    end
  endtask

  // The cycle after '#' is registered: present the verdict for one edge.
  task automatic load_cycle(input logic [1:0] ft);
    bus_if.char        = 8'h20;
    bus_if.format_type = ft;
    tick();
    bus_if.format_type = 2'd0;
  endtask

  task automatic chk_rec(input string tag, input logic [1:0] t, input logic [15:0] tm,
                         input logic [31:0] pc, input logic [31:0] dst, input logic [31:0] data);
    chk({tag, "_type"}, {30'd0, bus_if.rec_type}, {30'd0, t});
    chk({tag, "_time"}, {16'd0, bus_if.rec_time}, {16'd0, tm});
    chk({tag, "_pc"},   bus_if.rec_pc,   pc);
    chk({tag, "_dst"},  bus_if.rec_dst,  dst);
    chk({tag, "_data"}, bus_if.rec_data, data);
  endtask

  string l1 = "^242@000030f4: $31 <= 12345678#";
  string l2 = "^338@00003130: *00000088 <= ffffb528#";
  string l3 = "^100@00003134: $5 <= 1232158998#";
  string l4 = "^70000@ABC12: $7 <= deadbeef#";

  initial begin
    reset              = 1'b1;
    bus_if.char        = 8'h00;
    bus_if.format_type = 2'd0;
    bus_if.rec_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus_if.rec_valid}, 32'd0);
    chk("rst_ovf",   {31'd0, bus_if.overflow},  32'd0);
    chk_rec("rst", 2'd0, 16'd0, 32'd0, 32'd0, 32'd0);
    reset = 1'b0;
    tick();

    // register write, accepted immediately
    send_str(l1);
    load_cycle(2'd1);
    chk("l1_valid", {31'd0, bus_if.rec_valid}, 32'd1);
    chk_rec("l1", 2'd1, 16'd242, 32'h000030F4, 32'd31, 32'h12345678);
    tick();
    chk("l1_valid_clr", {31'd0, bus_if.rec_valid}, 32'd0);

    // memory write
    send_str(l2);
    load_cycle(2'd2);
    chk("l2_valid", {31'd0, bus_if.rec_valid}, 32'd1);
    chk_rec("l2", 2'd2, 16'd338, 32'h00003130, 32'h88, 32'hFFFFB528);
    tick();
    chk("l2_valid_clr", {31'd0, bus_if.rec_valid}, 32'd0);

    // rejected line: nothing captured
    send_str(l3);
    load_cycle(2'd0);
    chk("l3_valid", {31'd0, bus_if.rec_valid}, 32'd0);
    chk_rec("l3", 2'd2, 16'd338, 32'h00003130, 32'h88, 32'hFFFFB528);

    // time wraps at 16 bits, uppercase hex ignored
    send_str(l4);
    load_cycle(2'd1);
    chk("l4_valid", {31'd0, bus_if.rec_valid}, 32'd1);
    chk_rec("l4", 2'd1, 16'd4464, 32'h12, 32'd7, 32'hDEADBEEF);
    tick();

    // load on the accept edge replaces the record, valid stays high
    bus_if.rec_ready = 1'b0;
    send_str(l1);
    load_cycle(2'd1);
    chk("b2b_first_valid", {31'd0, bus_if.rec_valid}, 32'd1);
    send_str(l2);
    bus_if.rec_ready = 1'b1;
    load_cycle(2'd2);
    chk("b2b_valid", {31'd0, bus_if.rec_valid}, 32'd1);
    chk("b2b_ovf",   {31'd0, bus_if.overflow},  32'd0);
    chk_rec("b2b", 2'd2, 16'd338, 32'h00003130, 32'h88, 32'hFFFFB528);
    tick();
    chk("b2b_valid_clr", {31'd0, bus_if.rec_valid}, 32'd0);

    // backpressure: second record dropped, overflow sticky
    bus_if.rec_ready = 1'b0;
    send_str(l1);
    load_cycle(2'd1);
    chk("bp_valid1", {31'd0, bus_if.rec_valid}, 32'd1);
    chk("bp_ovf0",   {31'd0, bus_if.overflow},  32'd0);
    send_str(l2);
    load_cycle(2'd2);
    chk("bp_valid2", {31'd0, bus_if.rec_valid}, 32'd1);
    chk("bp_ovf1",   {31'd0, bus_if.overflow},  32'd1);
    chk_rec("bp_hold", 2'd1, 16'd242, 32'h000030F4, 32'd31, 32'h12345678);
    bus_if.rec_ready = 1'b1;
    tick();
    chk("bp_valid_clr", {31'd0, bus_if.rec_valid}, 32'd0);
    chk("bp_ovf_sticky", {31'd0, bus_if.overflow}, 32'd1);

    // reset mid-line discards the partial line
    send_str("^242@0000");
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus_if.rec_valid}, 32'd0);
    chk("mid_rst_ovf",   {31'd0, bus_if.overflow},  32'd0);
    chk_rec("mid_rst", 2'd0, 16'd0, 32'd0, 32'd0, 32'd0);
    tick();
    reset = 1'b0;
    send_str(l1);
    load_cycle(2'd1);
    chk("post_rst_valid", {31'd0, bus_if.rec_valid}, 32'd1);
    chk_rec("post_rst", 2'd1, 16'd242, 32'h000030F4, 32'd31, 32'h12345678);
    tick();
    chk("post_rst_clr", {31'd0, bus_if.rec_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
